// File: rtl/spi_driver_pkg.sv
// Shared types and constants for the SPI sprite driver: command opcodes,
// the command-decoder state encoding and the draw-queue entry layout.
package spi_driver_pkg;

    localparam logic [7:0] CMD_NOP    = 8'h00;
    localparam logic [7:0] CMD_DRAW   = 8'h01;
    localparam logic [7:0] CMD_SPRITE = 8'h02;

    // Data bytes in one sprite upload (two 4-bit pixels per byte)
    localparam int SPRITE_BYTES = 512;

    typedef enum logic [3:0] {
        IDLE,
        DRAW_ID,
        DRAW_XH,
        DRAW_XL,
        DRAW_YH,
        DRAW_YL,
        DRAW_SCALE,
        SPR_ID,
        SPR_DATA,
        END
    } spi_state_t;

    typedef struct packed {
        logic [7:0]  id;
        logic [15:0] x;
        logic [15:0] y;
        logic [7:0]  scale;
    } draw_entry_t;

endpackage

// File: rtl/spi_sprite_driver_draw_fifo.sv
// draw_fifo: first-word-fall-through queue of draw entries. The head entry is
// presented combinationally; outputs read as zero while the queue is empty.
// A push into a full queue is dropped unless a pop happens in the same cycle.
module draw_fifo
    import spi_driver_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  draw_entry_t push_data,
    input  logic        pop,
    output logic        is_empty,
    output draw_entry_t head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    draw_entry_t    mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           is_full;
    logic           do_push;
    logic           do_pop;

    assign is_empty = (count == '0);
    assign is_full  = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop & ~is_empty;
    assign do_push  = push & (~is_full | do_pop);
    assign head     = is_empty ? '0 : mem[rd_ptr];

    // Entry storage; no reset needed since empty slots are never shown
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spi_sprite_driver.sv
// spi_sprite_driver: SPI slave command decoder for the sprite renderer.
// Receives byte commands, writes uploaded sprite pixels into an inline 4-bit
// sprite RAM and queues draw requests in a FWFT draw_fifo.
// Optional feature macro: SPI_MISO_ECHO_EN (echo the previous byte on MISO).
module spi_sprite_driver
    import spi_driver_pkg::*;
#(
    parameter int SPRITE_ADDR_SIZE = 13,
    parameter int QUEUE_DEPTH      = 16
) (
    input  logic                      sys_clock,
    input  logic                      sys_reset_n,
    input  logic                      spi_cs,
    input  logic                      spi_sck,
    input  logic                      spi_mosi,
    output logic                      spi_miso,
    input  logic                      sprite_r_en,
    input  logic [SPRITE_ADDR_SIZE:0] sprite_r_addr,
    output logic [3:0]                sprite_r_data,
    input  logic                      dequeue,
    output logic                      is_empty,
    output logic [7:0]                sprite_id,
    output logic [15:0]               sprite_x,
    output logic [15:0]               sprite_y,
    output logic [7:0]                sprite_scale
);

    localparam int ADDR_W = SPRITE_ADDR_SIZE + 1;
    localparam int ID_W   = ADDR_W - 10;

    logic [1:0]        cs_sync;
    logic [1:0]        sck_sync;
    logic [1:0]        mosi_sync;
    logic              cs_s;
    logic              sck_s;
    logic              mosi_s;
    logic              sck_d;
    logic              sck_rise;

    logic [6:0]        shift_q;
    logic [2:0]        bit_cnt;
    logic              byte_valid;
    logic [7:0]        rx_byte;

    spi_state_t        state_q;
    spi_state_t        state_d;
    logic              push;
    logic              spr_we_hi;

    logic [7:0]        draw_id_q;
    logic [15:0]       draw_x_q;
    logic [15:0]       draw_y_q;
    logic [ID_W-1:0]   spr_id_q;
    logic [8:0]        byte_cnt_q;
    logic              low_pending;
    logic [3:0]        low_nib;
    logic [ADDR_W-1:0] low_addr;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [3:0]        ram_wdata;
    logic [3:0]        sprite_mem [2**ADDR_W];

    draw_entry_t       push_entry;
    draw_entry_t       head;

    assign cs_s     = cs_sync[1];
    assign sck_s    = sck_sync[1];
    assign mosi_s   = mosi_sync[1];
    assign sck_rise = sck_s & ~sck_d;

    // Two-flop synchronizers; CS and SCK reset to their idle-high levels
    always_ff @(posedge sys_clock or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            cs_sync   <= 2'b11;
            sck_sync  <= 2'b11;
            mosi_sync <= 2'b00;
            sck_d     <= 1'b1;
        end else begin
            cs_sync   <= {cs_sync[0], spi_cs};
            sck_sync  <= {sck_sync[0], spi_sck};
            mosi_sync <= {mosi_sync[0], spi_mosi};
            sck_d     <= sck_s;
        end
    end

    // Bit assembly: shift MOSI on each SCK rise, flag a byte after 8 bits
    always_ff @(posedge sys_clock or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            shift_q    <= '0;
            bit_cnt    <= '0;
            byte_valid <= 1'b0;
            rx_byte    <= '0;
        end else begin
            byte_valid <= 1'b0;
            if (cs_s) begin
                bit_cnt <= '0;
            end else if (sck_rise) begin
                shift_q <= {shift_q[5:0], mosi_s};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_valid <= 1'b1;
                    rx_byte    <= {shift_q, mosi_s};
                end
            end
        end
    end

    // Command decoder state register
    always_ff @(posedge sys_clock or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; deselect aborts any command back to IDLE
    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        spr_we_hi = 1'b0;
        if (cs_s) begin
            state_d = IDLE;
        end else if (byte_valid) begin
            case (state_q)
                IDLE: begin
                    if (rx_byte == CMD_DRAW) begin
                        state_d = DRAW_ID;
                    end else if (rx_byte == CMD_SPRITE) begin
                        state_d = SPR_ID;
                    end
                end
                DRAW_ID:    state_d = DRAW_XH;
                DRAW_XH:    state_d = DRAW_XL;
                DRAW_XL:    state_d = DRAW_YH;
                DRAW_YH:    state_d = DRAW_YL;
                DRAW_YL:    state_d = DRAW_SCALE;
                DRAW_SCALE: begin
                    push    = 1'b1;
                    state_d = END;
                end
                SPR_ID:     state_d = SPR_DATA;
                SPR_DATA: begin
                    spr_we_hi = 1'b1;
                    if (byte_cnt_q == 9'(SPRITE_BYTES - 1)) begin
                        state_d = END;
                    end
                end
                END:        state_d = IDLE;
                default:    state_d = IDLE;
            endcase
        end
    end

    // Capture command operands as their bytes arrive
    always_ff @(posedge sys_clock or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            draw_id_q  <= '0;
            draw_x_q   <= '0;
            draw_y_q   <= '0;
            spr_id_q   <= '0;
            byte_cnt_q <= '0;
        end else if (byte_valid && !cs_s) begin
            case (state_q)
                DRAW_ID:  draw_id_q      <= rx_byte;
                DRAW_XH:  draw_x_q[15:8] <= rx_byte;
                DRAW_XL:  draw_x_q[7:0]  <= rx_byte;
                DRAW_YH:  draw_y_q[15:8] <= rx_byte;
                DRAW_YL:  draw_y_q[7:0]  <= rx_byte;
                SPR_ID: begin
                    spr_id_q   <= rx_byte[ID_W-1:0];
                    byte_cnt_q <= '0;
                end
                SPR_DATA: byte_cnt_q <= byte_cnt_q + 9'd1;
                default: ;
            endcase
        end
    end

    // The low nibble of an upload byte is written one cycle after the high one
    always_ff @(posedge sys_clock or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            low_pending <= 1'b0;
            low_nib     <= '0;
            low_addr    <= '0;
        end else begin
            low_pending <= spr_we_hi;
            if (spr_we_hi) begin
                low_nib  <= rx_byte[3:0];
                low_addr <= {spr_id_q, byte_cnt_q, 1'b1};
            end
        end
    end

    assign ram_we    = spr_we_hi | low_pending;
    assign ram_waddr = spr_we_hi ? {spr_id_q, byte_cnt_q, 1'b0} : low_addr;
    assign ram_wdata = spr_we_hi ? rx_byte[7:4] : low_nib;

    // Sprite RAM write port
    always_ff @(posedge sys_clock) begin
        if (ram_we) begin
            sprite_mem[ram_waddr] <= ram_wdata;
        end
    end

    // Registered read port; same-cycle collisions return the old pixel
    always_ff @(posedge sys_clock or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            sprite_r_data <= '0;
        end else if (sprite_r_en) begin
            sprite_r_data <= sprite_mem[sprite_r_addr];
        end
    end

    assign push_entry = {draw_id_q, draw_x_q, draw_y_q, rx_byte};

    draw_fifo #(
        .DEPTH(QUEUE_DEPTH)
    ) u_draw_fifo (
        .clk       (sys_clock),
        .rst_n     (sys_reset_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (dequeue),
        .is_empty  (is_empty),
        .head      (head)
    );

    assign sprite_id    = head.id;
    assign sprite_x     = head.x;
    assign sprite_y     = head.y;
    assign sprite_scale = head.scale;

`ifdef SPI_MISO_ECHO_EN
    logic       sck_fall;
    logic [6:0] tx_shift_q;
    logic       miso_q;

    assign sck_fall = ~sck_s & sck_d;

    // Echo the last received byte, reloading at the first fall of each byte
    always_ff @(posedge sys_clock or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            tx_shift_q <= '0;
            miso_q     <= 1'b0;
        end else if (cs_s) begin
            tx_shift_q <= '0;
            miso_q     <= 1'b0;
        end else if (sck_fall) begin
            if (bit_cnt == 3'd0) begin
                miso_q     <= rx_byte[7];
                tx_shift_q <= rx_byte[6:0];
            end else begin
                miso_q     <= tx_shift_q[6];
                tx_shift_q <= {tx_shift_q[5:0], 1'b0};
            end
        end
    end

    assign spi_miso = miso_q;
`else
    assign spi_miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_sprite_driver.sv
// Self-checking bench for spi_sprite_driver: randomized draw commands and
// sprite uploads checked against a queue/array reference model.
module tb_spi_sprite_driver;

    localparam int DEPTH = 16;

    logic        sys_clock = 1'b0;
    logic        sys_reset_n = 1'b0;
    logic        spi_cs = 1'b1;
    logic        spi_sck = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic        sprite_r_en = 1'b0;
    logic [13:0] sprite_r_addr = '0;
    logic [3:0]  sprite_r_data;
    logic        dequeue = 1'b0;
    logic        is_empty;
    logic [7:0]  sprite_id;
    logic [15:0] sprite_x;
    logic [15:0] sprite_y;
    logic [7:0]  sprite_scale;

    int checks = 0;
    int errors = 0;

    // Reference model: draw queue of {id, x, y, scale} and a pixel array
    logic [47:0] model_q [$];
    logic [3:0]  ram_model [0:16383];

    spi_sprite_driver dut (
        .sys_clock     (sys_clock),
        .sys_reset_n   (sys_reset_n),
        .spi_cs        (spi_cs),
        .spi_sck       (spi_sck),
        .spi_mosi      (spi_mosi),
        .spi_miso      (spi_miso),
        .sprite_r_en   (sprite_r_en),
        .sprite_r_addr (sprite_r_addr),
        .sprite_r_data (sprite_r_data),
        .dequeue       (dequeue),
        .is_empty      (is_empty),
        .sprite_id     (sprite_id),
        .sprite_x      (sprite_x),
        .sprite_y      (sprite_y),
        .sprite_scale  (sprite_scale)
    );

    always #5 sys_clock = ~sys_clock;

    function automatic logic [48:0] expected_head();
        if (model_q.size() == 0) return {1'b1, 48'h0};
        return {1'b0, model_q[0]};
    endfunction

    function automatic logic [47:0] rand_entry();
        logic [31:0] a;
        logic [31:0] b;
        a = $urandom;
        b = $urandom;
        return {a, b[15:0]};
    endfunction

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            spi_sck  = 1'b0;
            spi_mosi = b[i];
            #20;
            spi_sck  = 1'b1;
            #20;
        end
    endtask

    task automatic cs_begin();
        @(negedge sys_clock);
        spi_cs = 1'b0;
        #40;
    endtask

    task automatic cs_end();
        #100;
        spi_cs = 1'b1;
        #100;
    endtask

    task automatic send_draw(input logic [47:0] e);
        cs_begin();
        spi_byte(8'h01);
        spi_byte(e[47:40]);
        spi_byte(e[39:32]);
        spi_byte(e[31:24]);
        spi_byte(e[23:16]);
        spi_byte(e[15:8]);
        spi_byte(e[7:0]);
        spi_byte(8'h00);
        cs_end();
        if (model_q.size() < DEPTH) model_q.push_back(e);
    endtask

    task automatic do_dequeue();
        @(negedge sys_clock);
        dequeue = 1'b1;
        @(negedge sys_clock);
        dequeue = 1'b0;
        if (model_q.size() > 0) void'(model_q.pop_front());
    endtask

    task automatic applyStimulus_reset();
        sys_reset_n = 1'b0;
        repeat (4) @(negedge sys_clock);
        sys_reset_n = 1'b1;
        repeat (4) @(negedge sys_clock);
    endtask

    task automatic test_reset();
        applyStimulus_reset();
        checks++;
        if (is_empty !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_is_empty got %b want 1", is_empty);
        end
        checks++;
        if ({sprite_id, sprite_x, sprite_y, sprite_scale} !== 48'h0) begin
            errors++;
            $display("[TB] FAIL reset_head got %h want 0", {sprite_id, sprite_x, sprite_y, sprite_scale});
        end
        checks++;
        if (sprite_r_data !== 4'h0) begin
            errors++;
            $display("[TB] FAIL reset_r_data got %h want 0", sprite_r_data);
        end
        checks++;
        if (spi_miso !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_miso got %b want 0", spi_miso);
        end
    endtask

    task automatic test_upload();
        logic [7:0]  bv;
        logic [13:0] a;
        logic [3:0]  held;
        int          ks [$];
        cs_begin();
        spi_byte(8'h02);
        spi_byte(8'h02);
        for (int n = 0; n < 512; n++) begin
            bv = 8'(n);
            spi_byte(bv);
            ram_model[{4'd2, 10'(2 * n)}]     = bv[7:4];
            ram_model[{4'd2, 10'(2 * n + 1)}] = bv[3:0];
        end
        spi_byte(8'h00);
        cs_end();
        ks = '{0, 1, 255, 256, 511};
        for (int r = 0; r < 12; r++) ks.push_back(int'($urandom_range(511)));
        foreach (ks[j]) begin
            for (int lo = 0; lo < 2; lo++) begin
                a = {4'd2, 10'(2 * ks[j] + lo)};
                @(negedge sys_clock);
                sprite_r_en   = 1'b1;
                sprite_r_addr = a;
                @(negedge sys_clock);
                sprite_r_en   = 1'b0;
                checks++;
                if (sprite_r_data !== ram_model[a]) begin
                    errors++;
                    $display("[TB] FAIL upload_read addr %h got %h want %h", a, sprite_r_data, ram_model[a]);
                end
            end
        end
        held = ram_model[a];
        sprite_r_addr = {4'd2, 10'd6};
        repeat (3) @(negedge sys_clock);
        checks++;
        if (sprite_r_data !== held) begin
            errors++;
            $display("[TB] FAIL read_hold got %h want %h", sprite_r_data, held);
        end
    endtask

    task automatic test_draw();
        send_draw({8'h01, 16'h0101, 16'h0101, 8'h02});
        checks++;
        if ({is_empty, sprite_id, sprite_x, sprite_y, sprite_scale} !== {1'b0, 8'h01, 16'h0101, 16'h0101, 8'h02}) begin
            errors++;
            $display("[TB] FAIL draw_first got %h", {is_empty, sprite_id, sprite_x, sprite_y, sprite_scale});
        end
        send_draw({8'h02, 16'h0303, 16'h0109, 8'h00});
        checks++;
        if ({is_empty, sprite_id, sprite_x, sprite_y, sprite_scale} !== expected_head()) begin
            errors++;
            $display("[TB] FAIL draw_second_push got %h want %h", {is_empty, sprite_id, sprite_x, sprite_y, sprite_scale}, expected_head());
        end
        do_dequeue();
        checks++;
        if ({is_empty, sprite_id, sprite_x, sprite_y, sprite_scale} !== {1'b0, 8'h02, 16'h0303, 16'h0109, 8'h00}) begin
            errors++;
            $display("[TB] FAIL draw_pop1 got %h", {is_empty, sprite_id, sprite_x, sprite_y, sprite_scale});
        end
        do_dequeue();
        checks++;
        if (is_empty !== 1'b1) begin
            errors++;
            $display("[TB] FAIL draw_pop2_empty got %b want 1", is_empty);
        end
        do_dequeue();
        checks++;
        if ({is_empty, sprite_id, sprite_x, sprite_y, sprite_scale} !== expected_head()) begin
            errors++;
            $display("[TB] FAIL draw_pop_empty got %h want %h", {is_empty, sprite_id, sprite_x, sprite_y, sprite_scale}, expected_head());
        end
    endtask

    task automatic test_abort();
        cs_begin();
        spi_byte(8'h01);
        spi_byte(8'h55);
        spi_byte(8'h12);
        #60;
        spi_cs = 1'b1;
        #100;
        checks++;
        if (is_empty !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_no_push got %b want 1", is_empty);
        end
        send_draw(rand_entry());
        while (1) begin
            checks++;
            if ({is_empty, sprite_id, sprite_x, sprite_y, sprite_scale} !== expected_head()) begin
                errors++;
                $display("[TB] FAIL abort_head got %h want %h", {is_empty, sprite_id, sprite_x, sprite_y, sprite_scale}, expected_head());
            end
            if (model_q.size() == 0) break;
            do_dequeue();
        end
    endtask

    task automatic test_ignored_opcode();
        logic [47:0] e;
        e = rand_entry();
        cs_begin();
        spi_byte(8'h7F);
        spi_byte(8'h00);
        spi_byte(8'hFF);
        spi_byte(8'h01);
        spi_byte(e[47:40]);
        spi_byte(e[39:32]);
        spi_byte(e[31:24]);
        spi_byte(e[23:16]);
        spi_byte(e[15:8]);
        spi_byte(e[7:0]);
        cs_end();
        model_q.push_back(e);
        checks++;
        if ({is_empty, sprite_id, sprite_x, sprite_y, sprite_scale} !== expected_head()) begin
            errors++;
            $display("[TB] FAIL ignored_opcode got %h want %h", {is_empty, sprite_id, sprite_x, sprite_y, sprite_scale}, expected_head());
        end
        do_dequeue();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH + 1; i++) send_draw(rand_entry());
        for (int i = 0; i < DEPTH + 1; i++) begin
            checks++;
            if ({is_empty, sprite_id, sprite_x, sprite_y, sprite_scale} !== expected_head()) begin
                errors++;
                $display("[TB] FAIL overflow_head idx %0d got %h want %h", i, {is_empty, sprite_id, sprite_x, sprite_y, sprite_scale}, expected_head());
            end
            do_dequeue();
        end
    endtask

    task automatic test_partial_upload();
        logic [7:0]  bv;
        logic [13:0] a;
        cs_begin();
        spi_byte(8'h02);
        spi_byte(8'h05);
        for (int n = 0; n < 10; n++) begin
            bv = 8'($urandom);
            spi_byte(bv);
            ram_model[{4'd5, 10'(2 * n)}]     = bv[7:4];
            ram_model[{4'd5, 10'(2 * n + 1)}] = bv[3:0];
        end
        cs_end();
        for (int p = 0; p < 20; p++) begin
            a = {4'd5, 10'(p)};
            @(negedge sys_clock);
            sprite_r_en   = 1'b1;
            sprite_r_addr = a;
            @(negedge sys_clock);
            sprite_r_en   = 1'b0;
            checks++;
            if (sprite_r_data !== ram_model[a]) begin
                errors++;
                $display("[TB] FAIL partial_read addr %h got %h want %h", a, sprite_r_data, ram_model[a]);
            end
        end
        send_draw(rand_entry());
        checks++;
        if ({is_empty, sprite_id, sprite_x, sprite_y, sprite_scale} !== expected_head()) begin
            errors++;
            $display("[TB] FAIL after_partial_draw got %h want %h", {is_empty, sprite_id, sprite_x, sprite_y, sprite_scale}, expected_head());
        end
        do_dequeue();
    endtask

    task automatic test_random_mixed();
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(1) == 1) send_draw(rand_entry());
            else do_dequeue();
            checks++;
            if ({is_empty, sprite_id, sprite_x, sprite_y, sprite_scale} !== expected_head()) begin
                errors++;
                $display("[TB] FAIL mixed_head step %0d got %h want %h", i, {is_empty, sprite_id, sprite_x, sprite_y, sprite_scale}, expected_head());
            end
        end
    endtask

    initial begin
        test_reset();
        test_upload();
        test_draw();
        test_abort();
        test_ignored_opcode();
        test_overflow();
        test_partial_upload();
        test_random_mixed();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_sprite_driver.md
# spi_sprite_driver

SPI slave front end for the sprite renderer. Decodes byte commands from the host MCU, stores uploaded 4-bit sprite bitmaps in an internal sprite RAM, and queues draw requests for the renderer. The renderer reads the sprite RAM and pops the draw queue on its own schedule in the `sys_clock` domain.

## Interface
Parameters:
- `SPRITE_ADDR_SIZE`, default 13: MSB index of the sprite RAM address. The RAM holds 2^(SPRITE_ADDR_SIZE+1) 4-bit pixels, which is 16 sprites of 1024 pixels.
- `QUEUE_DEPTH`, default 16: number of draw-queue entries; must be a power of 2.

Ports:
- `sys_clock` in 1: the single system clock; all logic is on its rising edge.
- `sys_reset_n` in 1: asynchronous, active-low reset.
- `spi_cs` in 1: chip select, active low, asynchronous to `sys_clock`.
- `spi_sck` in 1: SPI clock; idles high.
- `spi_mosi` in 1: host data, MSB first.
- `spi_miso` out 1: slave data (see Configuration).
- `sprite_r_en` in 1: sprite RAM read enable.
- `sprite_r_addr` in SPRITE_ADDR_SIZE+1: pixel address, formed as {sprite_id low bits, pixel index[9:0]}.
- `sprite_r_data` out 4: pixel value.
- `dequeue` in 1: pop the head of the draw queue.
- `is_empty` out 1: draw queue is empty.
- `sprite_id` out 8: sprite ID of the head entry.
- `sprite_x` out 16: X position of the head entry.
- `sprite_y` out 16: Y position of the head entry.
- `sprite_scale` out 8: scale of the head entry.

## Operation
- `spi_cs`, `spi_sck` and `spi_mosi` each pass through a 2-flop synchronizer. `spi_mosi` is sampled on the synchronized rising edge of `spi_sck`, MSB first, 8 bits per byte.
- Bit and byte state resets while `spi_cs` is high.
- FSM states: IDLE, DRAW_ID, DRAW_XH, DRAW_XL, DRAW_YH, DRAW_YL, DRAW_SCALE, SPR_ID, SPR_DATA, END.
- IDLE transitions on a received byte:
  - 0x01 goes to DRAW_ID.
  - 0x02 goes to SPR_ID.
  - Any other byte, including 0x00, is ignored and the FSM stays in IDLE.
- Draw command: the bytes are id, x[15:8], x[7:0], y[15:8], y[7:0], scale.
  - When the scale byte completes, the entry is pushed to the queue and the FSM goes to END.
  - If the queue is full, the entry is dropped silently.
- Sprite upload: the ID byte is followed by 512 data bytes, which are 1024 pixels.
  - Byte n writes pixel 2n from its high nibble and pixel 2n+1 from its low nibble, at address {id, index}.
  - After byte 511 the FSM goes to END.
- END: the next byte, nominally 0x00, returns the FSM to IDLE.
- `spi_cs` rising aborts to IDLE from any state:
  - A partial draw is discarded.
  - Pixels already written by a partial upload remain.
- Sprite RAM read port: synchronous. When `sprite_r_en`=1 at an edge, `sprite_r_data` updates the next cycle. When `sprite_r_en`=0, `sprite_r_data` holds its value.
- Sprite RAM read/write collision: a read of an address written in the same cycle returns the old data.
- Draw queue: first-word-fall-through FIFO.
  - `sprite_*` always show the head entry and are valid whenever `is_empty`=0.
  - `dequeue` while empty is ignored.
  - A simultaneous push and pop is allowed and leaves the count unchanged.
- Reset values:
  - FSM in IDLE, queue empty, `is_empty`=1.
  - `sprite_id`, `sprite_x`, `sprite_y`, `sprite_scale`, `sprite_r_data` and `spi_miso` are all 0.
  - RAM contents are undefined.

## Timing
- `spi_sck` high and low phases must each last at least 1 `sys_clock` period.
- A byte is complete 3 cycles after the `sys_clock` edge that samples its 8th `spi_sck` rise (2 synchronizer cycles plus 1 edge-detect cycle).
- `is_empty` falls at most 5 cycles after the scale byte's 8th `spi_sck` rise.
- Pop: at an edge with `dequeue`=1 and `is_empty`=0, the head advances.
  - The new head, or `is_empty`=1 if the queue is now empty, is visible after that edge.
- Pixel writes occur within the byte period. Each byte performs 2 nibble writes in consecutive cycles.

## Configuration
- `SPI_MISO_ECHO_EN` defined: `spi_miso` shifts out the previously received byte, MSB first. It changes after each synchronized falling edge of `spi_sck` and is 0 while `spi_cs` is high.
- `SPI_MISO_ECHO_EN` undefined: `spi_miso` is tied to 0.

## Structure
- Package `spi_driver_pkg` contains:
  - Opcodes CMD_NOP=0x00, CMD_DRAW=0x01, CMD_SPRITE=0x02.
  - The FSM state enum.
  - The `draw_entry_t` struct {id[7:0], x[15:0], y[15:0], scale[7:0]}.
  - SPRITE_BYTES=512.
- Sub-module `draw_fifo`: parameterized FWFT FIFO of `draw_entry_t`.
- The sprite RAM is inferred inline.

## Test plan
- Reset, then idle → `is_empty`=1, all outputs 0, `spi_miso`=0.
- Upload: 0x02, id 0x02, bytes 0..511 (byte value = index mod 256), then 0x00. Read address {2, 2k} → `sprite_r_data` = high nibble of (k mod 256); read address {2, 2k+1} → low nibble; data appears 1 cycle after `sprite_r_en`.
- Draw: 0x01, 0x01, 0x01, 0x01, 0x01, 0x01, 0x02, 0x00 → `is_empty`=0, `sprite_id`=1, x=0x0101, y=0x0101, scale=2.
- Second draw: id 2, x=0x0303, y=0x0109, scale 0. Pulse `dequeue` for 1 cycle → head becomes id 2, x=0x0303, y=0x0109, scale 0. Pulse `dequeue` again → `is_empty`=1. A further `dequeue` → no change.
- Raise `spi_cs` after 3 bytes of a draw, then send a full draw → only the full draw is queued.
- Push QUEUE_DEPTH+1 draws → the first QUEUE_DEPTH are retained in order and the last is dropped.
